// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake, shifts and iterative multiply/divide.
// Multiply/divide hardware is built only when ALU_SEQ_MULDIV_EN is defined.
module alu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [3:0]            alu_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero,
    output logic                  busy
);
    // state | meaning
    // IDLE  | ready to accept an operation
    // BUSY  | iterating multiply/divide, one bit per cycle
    // DONE  | result held until out_ready
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic                  accept;
    logic                  go_busy;
    logic                  iter_done;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] simple_res;
    logic [DATA_WIDTH-1:0] fast_res;
    logic [DATA_WIDTH-1:0] iter_res;

    assign shamt     = operand_b[SHAMT_W-1:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        simple_res = '0;
        case (alu_ctrl)
            4'b0000: simple_res = operand_a + operand_b;
            4'b0001: simple_res = operand_a - operand_b;
            4'b0010: simple_res = operand_a & operand_b;
            4'b0011: simple_res = operand_a | operand_b;
            4'b0100: simple_res = operand_a ^ operand_b;
            4'b0101: simple_res = {{(DATA_WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            4'b0110: simple_res = {{(DATA_WIDTH-1){1'b0}}, operand_a < operand_b};
            4'b0111: simple_res = operand_a << shamt;
            4'b1000: simple_res = operand_a >> shamt;
            4'b1001: simple_res = $unsigned($signed(operand_a) >>> shamt);
            default: simple_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                    is_mul, is_div, div_signed, div_zero, div_ovf;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b, early_res;
    logic [CNT_W-1:0]        count;
    logic [2*DATA_WIDTH-1:0] acc, acc_nxt, mul_nxt, div_nxt;
    logic [DATA_WIDTH-1:0]   dvsr, quo, rem;
    logic [DATA_WIDTH:0]     mul_sum, rem_sh, diff;
    logic                    mul_q, hi_q, rem_q, neg_quo, neg_rem;

    assign busy = (state == BUSY);

    // Division corner cases are resolved at accept and never enter BUSY.
    always_comb begin
        is_mul     = (alu_ctrl[3:1] == 3'b101);
        is_div     = (alu_ctrl[3:2] == 2'b11);
        div_signed = ~alu_ctrl[0];
        div_zero   = (operand_b == '0);
        div_ovf    = div_signed && (operand_a == MOST_NEG) && (operand_b == '1);
        mag_a      = (div_signed && operand_a[DATA_WIDTH-1]) ? -operand_a : operand_a;
        mag_b      = (div_signed && operand_b[DATA_WIDTH-1]) ? -operand_b : operand_b;
        if (div_zero)
            early_res = alu_ctrl[1] ? operand_a : '1;
        else if (div_ovf)
            early_res = alu_ctrl[1] ? '0 : MOST_NEG;
        else
            early_res = '0;
        go_busy  = is_mul || (is_div && !div_zero && !div_ovf);
        fast_res = (is_mul || is_div) ? early_res : simple_res;
    end

    // acc holds {high, low}: product accumulator for multiply, {remainder, quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                + (acc[0] ? {1'b0, dvsr} : {(DATA_WIDTH+1){1'b0}});
        mul_nxt = {mul_sum, acc[DATA_WIDTH-1:1]};
        rem_sh  = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
        diff    = rem_sh - {1'b0, dvsr};
        div_nxt = diff[DATA_WIDTH] ? {rem_sh[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b0}
                                   : {diff[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
        acc_nxt = mul_q ? mul_nxt : div_nxt;
        quo     = acc_nxt[DATA_WIDTH-1:0];
        rem     = acc_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
        if (mul_q)
            iter_res = hi_q ? rem : quo;
        else if (rem_q)
            iter_res = neg_rem ? -rem : rem;
        else
            iter_res = neg_quo ? -quo : quo;
        iter_done = (state == BUSY) && (count == CNT_W'(DATA_WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            acc     <= '0;
            dvsr    <= '0;
            mul_q   <= 1'b0;
            hi_q    <= 1'b0;
            rem_q   <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept && go_busy) begin
            count   <= '0;
            acc     <= {{DATA_WIDTH{1'b0}}, is_mul ? operand_a : mag_a};
            dvsr    <= is_mul ? operand_b : mag_b;
            mul_q   <= is_mul;
            hi_q    <= alu_ctrl[0];
            rem_q   <= alu_ctrl[1];
            neg_quo <= div_signed && (operand_a[DATA_WIDTH-1] ^ operand_b[DATA_WIDTH-1]);
            neg_rem <= div_signed && operand_a[DATA_WIDTH-1];
        end else if ((state == BUSY) && !flush) begin
            count <= count + CNT_W'(1);
            acc   <= acc_nxt;
        end
    end
`else
    assign busy      = 1'b0;
    assign go_busy   = 1'b0;
    assign iter_done = 1'b0;
    assign iter_res  = '0;
    assign fast_res  = (alu_ctrl[3] && (alu_ctrl[2] || alu_ctrl[1])) ? '0 : simple_res;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = go_busy ? BUSY : DONE;
            BUSY:    if (iter_done) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result <= '0;
            zero       <= 1'b1;
        end else if (accept && !go_busy) begin
            alu_result <= fast_res;
            zero       <= (fast_res == '0);
        end else if (iter_done && !flush) begin
            alu_result <= iter_res;
            zero       <= (iter_res == '0);
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq; expectations follow ALU_SEQ_MULDIV_EN the same way the DUT does.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W = 32;
    localparam logic [W-1:0] MN = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [W-1:0] operand_a, operand_b, alu_result;
    logic [3:0]   alu_ctrl;

    int           n_tests = 0;
    int           n_fail = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$];

    always #5 clk = ~clk;

    alu_seq #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .alu_ctrl(alu_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] prod;
        prod = {32'b0, a} * {32'b0, b};
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0110: return (a < b) ? 32'd1 : 32'd0;
            4'b0111: return a << b[4:0];
            4'b1000: return a >> b[4:0];
            4'b1001: return $unsigned($signed(a) >>> b[4:0]);
`ifdef ALU_SEQ_MULDIV_EN
            4'b1010: return prod[31:0];
            4'b1011: return prod[63:32];
            4'b1100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MN && b == 32'hFFFF_FFFF) return MN;
                return $unsigned($signed(a) / $signed(b));
            end
            4'b1101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            4'b1110: begin
                if (b == 0) return a;
                if (a == MN && b == 32'hFFFF_FFFF) return 32'd0;
                return $unsigned($signed(a) % $signed(b));
            end
            4'b1111: begin
                if (b == 0) return a;
                return a % b;
            end
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ALU_SEQ_MULDIV_EN
        if (c == 4'b1010 || c == 4'b1011) return W + 1;
        if (c >= 4'b1100) begin
            if (b == 0) return 1;
            if (!c[0] && a == MN && b == 32'hFFFF_FFFF) return 1;
            return W + 1;
        end
`endif
        return 1;
    endfunction

    task automatic start_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_ctrl  = c;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        chk("in_ready_before_accept", in_ready, 1);
        exp_q.push_back(model(c, a, b));
        lat_q.push_back(exp_lat(c, a, b));
        tick();
        in_valid = 1'b0;
        alu_ctrl = 4'b1111;
    endtask

    task automatic wait_out(output int n, output int busy_n, output int nrdy_n);
        n = 1;
        busy_n = 0;
        nrdy_n = 0;
        while (!out_valid && n < 100) begin
            if (busy) busy_n++;
            if (!in_ready) nrdy_n++;
            tick();
            n++;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, alu_result, e);
            chk({tag, "_zero"}, zero, e == 0);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int n, busy_n, nrdy_n, lat;
        start_op(c, a, b);
        wait_out(n, busy_n, nrdy_n);
        lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_cycles"}, busy_n, lat - 1);
        chk({tag, "_ready_low"}, nrdy_n, lat - 1);
        pop_check(tag);
        tick();
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_n, nrdy_n, seen;
        logic [3:0]   c;
        logic [W-1:0] a, b, held;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = 4'b0; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", alu_result, 0);
        chk("rst_zero", zero, 1);
        rst = 1'b0;
        tick();

        run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1);
        run_op("sub_zero", 4'b0001, 32'd5, 32'd5);
        run_op("and", 4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00);
        run_op("or", 4'b0011, 32'hF000_0001, 32'h000F_0010);
        run_op("xor", 4'b0100, 32'hAAAA_5555, 32'hFFFF_0000);
        run_op("sra", 4'b1001, 32'h8000_0000, 32'd4);
        run_op("srl", 4'b1000, 32'h8000_0000, 32'd4);
        run_op("sll", 4'b0111, 32'h0000_0081, 32'h0000_0023);
        run_op("slt", 4'b0101, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu", 4'b0110, 32'hFFFF_FFFF, 32'd1);
        run_op("mul", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg", 4'b1100, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_neg", 4'b1110, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_by0", 4'b1101, 32'd7, 32'd0);
        run_op("rem_ovf", 4'b1110, MN, 32'hFFFF_FFFF);
        run_op("div_ovf", 4'b1100, MN, 32'hFFFF_FFFF);
        run_op("remu_by0", 4'b1111, 32'h1234_5678, 32'd0);
        run_op("div_negb", 4'b1100, 32'd100, 32'hFFFF_FFF9);
        run_op("remu", 4'b1111, 32'hDEAD_BEEF, 32'd1000);

        for (int i = 0; i < 24; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (c >= 4'b1100 && $urandom_range(0, 3) == 0) b = '0;
            if (c >= 4'b1100 && $urandom_range(0, 5) == 0) begin a = MN; b = '1; end
            if (c <= 4'b0110 && $urandom_range(0, 3) == 0) b = a;
            run_op("rand", c, a, b);
        end

        // backpressure: result must hold while a competing request is offered
        out_ready = 1'b0;
        start_op(4'b1101, 32'd100, 32'd7);
        wait_out(n, busy_n, nrdy_n);
        chk("bp_latency", n, (lat_q.size() > 0) ? lat_q.pop_front() : -1);
        held = (exp_q.size() > 0) ? exp_q[0] : '0;
        alu_ctrl = 4'b0000; operand_a = 32'd1; operand_b = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_held", out_valid, 1);
            chk("bp_result_held", alu_result, held);
            chk("bp_in_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        pop_check("bp");
        tick();
        chk("bp_idle_valid", out_valid, 0);
        chk("bp_idle_ready", in_ready, 1);
        tick();
        chk("bp_no_ghost", out_valid, 0);

        // async reset in the middle of a divide
        out_ready = 1'b0;
        start_op(4'b1101, 32'd1000, 32'd3);
        repeat (9) tick();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_result", alu_result, 0);
        chk("mid_rst_zero", zero, 1);
        exp_q.delete();
        lat_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        chk("post_rst_no_stale", seen, 0);
        run_op("post_rst_add", 4'b0000, 32'd2, 32'd3);

        // flush in the middle of a multiply, with a competing request
        out_ready = 1'b0;
        start_op(4'b1010, 32'd12345, 32'd6789);
        repeat (8) tick();
        flush = 1'b1;
        alu_ctrl = 4'b0000; operand_a = 32'd9; operand_b = 32'd9; in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_busy", busy, 0);
        exp_q.delete();
        lat_q.delete();
        out_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        chk("post_flush_no_stale", seen, 0);
        run_op("post_flush_add", 4'b0000, 32'd2, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle successor to the single-cycle execute-stage ALU.
- Parametrised datapath width; adds shifts plus RV32M-style multiply, divide and remainder.
- Valid/ready handshake on both sides, so the CPU pipeline can stall on long operations.
- Iterative multiply/divide run only while busy; idle datapath registers hold, which makes them clock-gating friendly.

Parameters:
- DATA_WIDTH, 32: operand and result width. Must be a power of two, >= 8.
- SHAMT_W, $clog2(DATA_WIDTH): shift-amount bits, taken from operand_b[SHAMT_W-1:0]. Derived; not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the in-flight operation.
- in_valid  in  1  operands and alu_ctrl valid.
- in_ready  out  1  block can accept an operation.
- operand_a  in  DATA_WIDTH  rs1.
- operand_b  in  DATA_WIDTH  rs2 or immediate.
- alu_ctrl  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- alu_result  out  DATA_WIDTH  registered result.
- zero  out  1  registered, (alu_result == 0).
- busy  out  1  high in BUSY state.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA.
  - 1010 MUL (low half), 1011 MULHU (high half, unsigned).
  - 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
- Arithmetic wraps modulo 2^DATA_WIDTH.
- SLT and SLTU results are zero-extended 0 or 1.
- States:
  - IDLE -> DONE when a simple op is accepted.
  - IDLE -> BUSY when a multiply/divide op is accepted.
  - BUSY -> DONE when the iteration counter reaches DATA_WIDTH.
  - DONE -> IDLE when out_ready is high.
- Accept: in_valid && in_ready. in_ready = (state == IDLE). Operands and opcode are captured at accept.
- Simple ops (0000-1001): result registered at accept; out_valid is high the next cycle (latency 1).
- Multiply: radix-2 shift-add, one bit per cycle, 2*DATA_WIDTH-bit accumulator. out_valid at accept + DATA_WIDTH + 1.
- Divide: restoring, unsigned core, one bit per cycle. out_valid at accept + DATA_WIDTH + 1.
  - Signed ops: operands converted to magnitudes at accept.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide early-out cases (resolved at accept; skip BUSY and go straight to DONE, latency 1):
  - divisor == 0: quotient = all ones; remainder = operand_a.
  - DIV/REM with operand_a = most-negative and operand_b = -1: quotient = most-negative; remainder = 0.
- DONE: alu_result, zero and out_valid are held stable until out_ready is sampled high. out_valid drops the cycle after the transfer.
- No accept while in DONE: no bypass, so there is at most one operation in flight.
- flush high: state -> IDLE next edge, out_valid -> 0, the pending result is discarded.
  - flush has priority over a simultaneous out_ready or in_valid; no accept occurs in that cycle.
- Iteration counter, accumulator and divisor registers update only in BUSY or on accept; otherwise they hold.
- Reset (async, at any time, including mid-BUSY):
  - state IDLE, in_ready 1, out_valid 0, busy 0.
  - alu_result 0, zero 1, counter 0.
- alu_ctrl value during BUSY is ignored.

Optional Feature:
- Macro ALU_SEQ_MULDIV_EN.
- Defined: opcodes 1010-1111 behave as specified above.
- Undefined:
  - Multiply/divide logic and the BUSY state are not synthesised.
  - Opcodes 1010-1111 complete in 1 cycle with alu_result 0 and zero 1.
  - busy is tied to 0.

Test Plan:
- ADD 0x7FFFFFFF + 1 with out_ready held 1 -> out_valid one cycle after accept; result 0x80000000, zero 0. SUB 5 - 5 -> result 0, zero 1.
- SRA 0x80000000 by 4 -> 0xF8000000. SRL 0x80000000 by 4 -> 0x08000000. SLT -1 vs 1 -> 1. SLTU -1 vs 1 -> 0.
- MUL 0xFFFFFFFF * 0xFFFFFFFF -> result 0x00000001 after exactly 33 cycles. MULHU same operands -> 0xFFFFFFFE. busy high for 32 cycles; in_ready low throughout.
- DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF. DIVU 7 / 0 -> 0xFFFFFFFF in 1 cycle. REM 0x80000000 / -1 -> 0 in 1 cycle.
- Backpressure: out_ready held 0 for 5 cycles after a DIVU result -> alu_result and out_valid stable; in_ready 0. out_ready pulsed -> IDLE next cycle.
- Assert rst at cycle 10 of a DIVU, and separately flush at cycle 10 of a MUL -> IDLE, out_valid 0, no stale result. The next ADD 2 + 3 returns 5.
